sram_wrbuf: RTL and testbench
=============================

Name: sram_wrbuf

Overview:
- Posted write buffer between the CPU data bus and sram_cache; its master port drives sram_cache's slave port.
- Writes are queued in a small FIFO, so the CPU continues while slow byte-wide SRAM writes drain behind it.
- Reads pass through to sram_cache once ordering against pending writes is guaranteed.
- Exposes an empty flag used by fence and DMA logic.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- s_addr  in  17  word address from CPU
- s_wrdata  in  32  write data
- s_bytesel  in  4  byte enables
- s_wren  in  1  1 = write, 0 = read
- s_strobe  in  1  request; held until completion
- s_wait  out  1  stall; the transfer completes at the posedge where s_strobe=1 and s_wait=0
- s_rddata  out  32  read data, valid in the completing cycle
- m_addr  out  17  to sram_cache
- m_wrdata  out  32  to sram_cache
- m_bytesel  out  4  to sram_cache
- m_wren  out  1  to sram_cache
- m_strobe  out  1  to sram_cache
- m_wait  in  1  from sram_cache
- m_rddata  in  32  from sram_cache
- wb_empty  out  1  1 when no writes are pending and no master transfer is active

Behaviour:
- Reset (reset_n=0, asynchronous):
  - FIFO pointers and count cleared; pending writes are discarded.
  - FSM goes to IDLE.
  - m_strobe=0; m_addr, m_wrdata, m_bytesel and m_wren are 0.
  - wb_empty=1; s_rddata=0.
  - Reset mid-transfer drops m_strobe immediately.
- FIFO entry is {addr[16:0], wrdata[31:0], bytesel[3:0]} (53 bits). Read/write pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Write accept: s_strobe & s_wren & !full.
  - s_wait is combinational: s_wait = full for writes.
  - The entry is pushed at that posedge, so the CPU sees zero wait cycles when not full.
  - A write to a full FIFO stalls until a pop frees an entry. s_wait drops in the cycle after the pop edge.
- FSM states: IDLE, DRAIN, READ.
  - IDLE: if the FIFO is non-empty, go to DRAIN. Otherwise, if a read is pending (s_strobe & !s_wren), go to READ. Drain has priority over reads.
  - DRAIN:
    - m_strobe=1, m_wren=1, m_* driven from the FIFO head.
    - At the posedge with m_wait=0, pop the head.
    - Then go to DRAIN again if entries remain and no read is eligible, else go to IDLE.
    - m_* stay stable while m_wait=1.
  - READ:
    - m_strobe=1, m_wren=0, m_addr=s_addr, m_bytesel=s_bytesel.
    - s_wait = m_wait and s_rddata = m_rddata, both combinational pass-through.
    - At the posedge with m_wait=0, go to IDLE.
    - Minimum read latency is one extra cycle over sram_cache.
  - While not in READ, s_rddata is 0 and a read sees s_wait=1.
- Simultaneous push and pop in one cycle: count unchanged, and both operations take effect.
- A push while full in the same cycle as a pop is NOT accepted; s_wait stays 1 that cycle. This keeps s_wait independent of m_wait.
- wb_empty = (count==0) & (state==IDLE).
- With s_strobe=0, no state changes except draining.

Optional Feature:
- Macro: SRAM_WRBUF_RAWCHK_EN.
- Defined:
  - A pending read compares s_addr against the addr of every valid FIFO entry.
  - No match: the read is eligible and is taken from IDLE ahead of pending writes. An in-flight drain is never aborted; the read waits for the current entry's pop.
  - Match: the FIFO drains until no valid entry matches, then the read issues.
- Not defined: every read waits until the FIFO is completely empty. No comparators are built.

Test Plan:
- After reset: wb_empty=1, m_strobe=0, s_wait=0 with s_strobe=0. Then write 0x55AABEEF to addr 0x00000 with bytesel 1111 -> completes with zero wait cycles; m_strobe rises the next cycle with m_addr=0, m_wrdata=0x55AABEEF; wb_empty=1 after the pop.
- Five back-to-back writes with DEPTH=4 and sram_cache stalling (m_wait held 1) -> the first four are accepted with no wait; the fifth sees s_wait=1 until the first pop. Entries appear on m_* in order with their bytesel (1111, 1000, 0100, 0010, 0001).
- Write 0x12345678 bytesel 1000 to addr 0x00000, then an immediate read of addr 0x00000 -> the read issues only after the pop; s_rddata=0x12AABEEF (prior contents 0x55AABEEF).
- With SRAM_WRBUF_RAWCHK_EN: queue three writes to 0x10000, then read 0x00000 -> m_wren=0 read appears after the current drain entry's pop, before the remaining writes. Without the macro: the read appears after all three writes.
- Assert reset_n=0 with two entries queued and m_strobe=1 -> m_strobe=0 asynchronously, wb_empty=1, no further m_strobe after release.
- Simultaneous push and pop at count=2 -> count stays 2; FIFO order preserved on m_addr.

Source files
------------

// File: rtl/sram_wrbuf.sv
// Posted write buffer in front of sram_cache: CPU writes queue in a FIFO and drain behind it,
// reads pass through once ordered. Optional read-after-write bypass: SRAM_WRBUF_RAWCHK_EN.
module sram_wrbuf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [16:0] s_addr,
  input  logic [31:0] s_wrdata,
  input  logic [3:0]  s_bytesel,
  input  logic        s_wren,
  input  logic        s_strobe,
  output logic        s_wait,
  output logic [31:0] s_rddata,
  output logic [16:0] m_addr,
  output logic [31:0] m_wrdata,
  output logic [3:0]  m_bytesel,
  output logic        m_wren,
  output logic        m_strobe,
  input  logic        m_wait,
  input  logic [31:0] m_rddata,
  output logic        wb_empty
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

  typedef struct packed {
    logic [16:0] addr;
    logic [31:0] wrdata;
    logic [3:0]  bytesel;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  state_t        state, state_nxt;

  logic full, empty, read_req, push, pop;
  logic read_ok_idle, read_ok_pop;
  entry_t head;

  // DEPTH is a power of two, so the top count bit alone marks a full FIFO.
  assign full     = count[AW];
  assign empty    = (count == '0);
  assign read_req = s_strobe & ~s_wren;
  assign push     = s_strobe & s_wren & ~full;
  assign pop      = (state == DRAIN) & ~m_wait;
  assign head     = mem[rd_ptr];
  assign wb_empty = empty & (state == IDLE);

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
  end

`ifdef SRAM_WRBUF_RAWCHK_EN
  logic [DEPTH-1:0] hit_any, hit_tail;
  logic [AW-1:0]    slot_off;

  // A slot is live when its distance from the head is below count; the head is
  // excluded from hit_tail because it leaves the FIFO at the current pop.
  always_comb begin
    hit_any  = '0;
    hit_tail = '0;
    slot_off = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot_off = AW'(k) - rd_ptr;
      if (({1'b0, slot_off} < count) && (mem[k].addr == s_addr)) begin
        hit_any[k]  = 1'b1;
        hit_tail[k] = (slot_off != '0);
      end
    end
  end

  assign read_ok_idle = read_req & ~|hit_any;
  assign read_ok_pop  = read_req & ~|hit_tail;
`else
  assign read_ok_idle = read_req & empty;
  assign read_ok_pop  = 1'b0;
`endif

  // NOTE: the entry storage has no reset; pointers and count alone decide validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: s_addr, wrdata: s_wrdata, bytesel: s_bytesel};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      state <= state_nxt;
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    m_strobe  = 1'b0;
    m_wren    = 1'b0;
    m_addr    = '0;
    m_wrdata  = '0;
    m_bytesel = '0;
    s_rddata  = '0;
    s_wait    = s_strobe & (s_wren ? full : 1'b1);

    unique case (state)
      IDLE: begin
        if (read_ok_idle) state_nxt = READ;
        else if (!empty)  state_nxt = DRAIN;
      end
      DRAIN: begin
        m_strobe  = 1'b1;
        m_wren    = 1'b1;
        m_addr    = head.addr;
        m_wrdata  = head.wrdata;
        m_bytesel = head.bytesel;
        if (!m_wait) begin
          state_nxt = ((count_nxt != '0) && !read_ok_pop) ? DRAIN : IDLE;
        end
      end
      READ: begin
        m_strobe  = 1'b1;
        m_addr    = s_addr;
        m_bytesel = s_bytesel;
        s_rddata  = m_rddata;
        if (read_req) s_wait = m_wait;
        if (!m_wait)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_wrbuf.sv
// Scoreboard bench for sram_wrbuf: stimulus queues expected master operations and read data,
// a negedge monitor compares them as transfers complete on either port.
module tb_sram_wrbuf;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [16:0] s_addr = '0;
  logic [31:0] s_wrdata = '0;
  logic [3:0]  s_bytesel = '0;
  logic        s_wren = 1'b0;
  logic        s_strobe = 1'b0;
  logic        s_wait;
  logic [31:0] s_rddata;
  logic [16:0] m_addr;
  logic [31:0] m_wrdata;
  logic [3:0]  m_bytesel;
  logic        m_wren;
  logic        m_strobe;
  logic        m_wait;
  logic [31:0] m_rddata;
  logic        wb_empty;
  logic        stall = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wren;
    logic [16:0] addr;
    logic [31:0] data;
    logic [3:0]  bs;
  } op_t;

  op_t         exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] sram [0:131071];

  sram_wrbuf #(.DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_bytesel(s_bytesel),
    .s_wren(s_wren), .s_strobe(s_strobe), .s_wait(s_wait), .s_rddata(s_rddata),
    .m_addr(m_addr), .m_wrdata(m_wrdata), .m_bytesel(m_bytesel),
    .m_wren(m_wren), .m_strobe(m_strobe), .m_wait(m_wait), .m_rddata(m_rddata),
    .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  // sram_cache stand-in: zero-wait unless stalled, byte-merged storage
  assign m_wait   = stall;
  assign m_rddata = sram[m_addr];

  always @(posedge clk) begin
    if (reset_n && m_strobe && m_wren && !m_wait) begin
      for (int b = 0; b < 4; b++)
        if (m_bytesel[b]) sram[m_addr][8*b +: 8] <= m_wrdata[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: one comparison per completed transfer on each port.
  always @(negedge clk) begin
    if (reset_n && m_strobe && !m_wait) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL m_xfer_unexpected actual wren=%0d addr=%0h expected none", m_wren, m_addr);
      end else begin
        op_t e;
        e = exp_q.pop_front();
        check("m_op", {m_wren, m_addr, m_bytesel}, {e.wren, e.addr, e.bs});
        if (e.wren) check("m_wrdata", m_wrdata, e.data);
      end
    end
    if (reset_n && s_strobe && !s_wren && !s_wait) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL s_read_unexpected actual=%0h expected none", s_rddata);
      end else begin
        check("s_rddata", s_rddata, rd_q.pop_front());
      end
    end
  end

  task automatic expect_w(input logic [16:0] a, input logic [31:0] d, input logic [3:0] bs);
    exp_q.push_back('{wren: 1'b1, addr: a, data: d, bs: bs});
  endtask

  task automatic expect_r(input logic [16:0] a, input logic [31:0] d);
    exp_q.push_back('{wren: 1'b0, addr: a, data: 32'h0, bs: 4'hF});
    rd_q.push_back(d);
  endtask

  // mode 0: expect zero wait, 1: expect an initial stall, 2: unchecked
  task automatic cpu_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] bs,
                           input int mode);
    int n = 0;
    s_addr = a; s_wrdata = d; s_bytesel = bs; s_wren = 1'b1; s_strobe = 1'b1;
    @(negedge clk);
    if (mode == 0)      check("wr_no_wait", s_wait, 1'b0);
    else if (mode == 1) check("wr_stall", s_wait, 1'b1);
    while (s_wait && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("wr_timeout", s_wait, 1'b0);
    @(posedge clk); #1;
    s_strobe = 1'b0; s_wren = 1'b0;
  endtask

  task automatic cpu_read(input logic [16:0] a);
    int n = 0;
    s_addr = a; s_bytesel = 4'hF; s_wren = 1'b0; s_strobe = 1'b1;
    @(negedge clk);
    while (s_wait && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("rd_timeout", s_wait, 1'b0);
    @(posedge clk); #1;
    s_strobe = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    @(negedge clk);
    while (!wb_empty && n < 200) begin @(negedge clk); n++; end
    check(name, wb_empty, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 131072; i++) sram[i] = 32'h0;

    // Reset state
    #1;
    check("rst_m_strobe", m_strobe, 1'b0);
    check("rst_wb_empty", wb_empty, 1'b1);
    check("rst_m_addr", {m_addr, m_wrdata, m_bytesel, m_wren}, 54'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("idle_wb_empty", wb_empty, 1'b1);
    check("idle_m_strobe", m_strobe, 1'b0);
    check("idle_s_wait", s_wait, 1'b0);
    check("idle_s_rddata", s_rddata, 32'h0);
    @(posedge clk); #1;

    // Single write, zero wait, drains to address 0
    expect_w(17'h0, 32'h55AABEEF, 4'b1111);
    cpu_write(17'h0, 32'h55AABEEF, 4'b1111, 0);
    n = 0;
    @(negedge clk);
    while (!m_strobe && n < 20) begin @(negedge clk); n++; end
    check("drain_m_strobe", m_strobe, 1'b1);
    check("drain_m_addr", m_addr, 17'h0);
    check("drain_m_wrdata", m_wrdata, 32'h55AABEEF);
    check("drain_m_wren", m_wren, 1'b1);
    @(posedge clk); #1;
    wait_empty("wb_empty_after_pop");

    // Five writes against a stalled sram_cache; the fifth waits for the first pop
    stall = 1'b1;
    expect_w(17'h11, 32'h11111111, 4'b1111);
    expect_w(17'h12, 32'h22222222, 4'b1000);
    expect_w(17'h13, 32'h33333333, 4'b0100);
    expect_w(17'h14, 32'h44444444, 4'b0010);
    expect_w(17'h15, 32'h55555555, 4'b0001);
    cpu_write(17'h11, 32'h11111111, 4'b1111, 0);
    cpu_write(17'h12, 32'h22222222, 4'b1000, 0);
    cpu_write(17'h13, 32'h33333333, 4'b0100, 0);
    cpu_write(17'h14, 32'h44444444, 4'b0010, 0);
    check("full_wb_empty", wb_empty, 1'b0);
    fork
      cpu_write(17'h15, 32'h55555555, 4'b0001, 1);
      begin
        repeat (3) @(posedge clk);
        #1 stall = 1'b0;
      end
    join
    wait_empty("wb_empty_after_five");

    // Write then read of the same word: read ordered after the pop, merged data
    expect_w(17'h0, 32'h12345678, 4'b1000);
    expect_r(17'h0, 32'h12AABEEF);
    cpu_write(17'h0, 32'h12345678, 4'b1000, 0);
    cpu_read(17'h0);
    wait_empty("wb_empty_after_raw");

    // Three writes elsewhere, then a read of address 0
    stall = 1'b1;
    expect_w(17'h10000, 32'hA1A1A1A1, 4'hF);
`ifdef SRAM_WRBUF_RAWCHK_EN
    expect_r(17'h0, 32'h12AABEEF);
    expect_w(17'h10000, 32'hA2A2A2A2, 4'hF);
    expect_w(17'h10000, 32'hA3A3A3A3, 4'hF);
`else
    expect_w(17'h10000, 32'hA2A2A2A2, 4'hF);
    expect_w(17'h10000, 32'hA3A3A3A3, 4'hF);
    expect_r(17'h0, 32'h12AABEEF);
`endif
    cpu_write(17'h10000, 32'hA1A1A1A1, 4'hF, 0);
    cpu_write(17'h10000, 32'hA2A2A2A2, 4'hF, 0);
    cpu_write(17'h10000, 32'hA3A3A3A3, 4'hF, 0);
    fork
      cpu_read(17'h0);
      begin
        repeat (2) @(posedge clk);
        #1 stall = 1'b0;
      end
    join
    wait_empty("wb_empty_after_bypass");

    // Push and pop on the same edge at count 2
    stall = 1'b1;
    expect_w(17'h21, 32'hC0DE0001, 4'hF);
    expect_w(17'h22, 32'hC0DE0002, 4'hF);
    expect_w(17'h23, 32'hC0DE0003, 4'hF);
    cpu_write(17'h21, 32'hC0DE0001, 4'hF, 0);
    cpu_write(17'h22, 32'hC0DE0002, 4'hF, 0);
    fork
      cpu_write(17'h23, 32'hC0DE0003, 4'hF, 0);
      begin
        stall = 1'b0;
        @(posedge clk);
        #1 stall = 1'b1;
      end
    join
    @(negedge clk);
    check("pushpop_count", dut.count, 3'd2);
    check("pushpop_head", m_addr, 17'h22);
    @(posedge clk); #1;
    stall = 1'b0;
    wait_empty("wb_empty_after_pushpop");

    // Reset with two entries queued and a drain in flight
    stall = 1'b1;
    cpu_write(17'h31, 32'hDEAD0001, 4'hF, 0);
    cpu_write(17'h32, 32'hDEAD0002, 4'hF, 0);
    n = 0;
    @(negedge clk);
    while (!m_strobe && n < 20) begin @(negedge clk); n++; end
    check("pre_reset_m_strobe", m_strobe, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_m_strobe", m_strobe, 1'b0);
    check("async_rst_wb_empty", wb_empty, 1'b1);
    check("async_rst_m_addr", m_addr, 17'h0);
    @(posedge clk); #1;
    stall = 1'b0;
    reset_n = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_strobe) n++;
    end
    check("no_strobe_after_reset", n, 0);
    check("post_reset_wb_empty", wb_empty, 1'b1);

    check("exp_q_drained", exp_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
